// File: rtl/apb_arb_pkg.sv
// rtl/apb_arb_pkg.sv - shared state encoding, widths and helpers for apb_req_arbiter
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Address bit that steers a transfer to slave2 (1) or gpio (0)
  localparam int SLV_SEL_BIT = 32;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_ADDR_W  = 33;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 64;

  // Bits needed to hold values 0..n-1, never less than one
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - round-robin pick: first set request at or above ptr, with wrap
module rr_priority_pick
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any_req
);

  logic [IDX_W-1:0] cand_idx;
  int               sum;

  // Walk the requesters starting at ptr; the first asserted one wins
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any_req    = 1'b0;
    cand_idx   = '0;
    sum        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = int'(ptr) + k;
      if (sum >= NUM_REQ) begin
        sum = sum - NUM_REQ;
      end
      cand_idx = IDX_W'(sum);
      if (!any_req && req[cand_idx]) begin
        any_req              = 1'b1;
        gnt_onehot[cand_idx] = 1'b1;
        gnt_idx              = cand_idx;
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - round-robin sharing of one APB master among NUM_REQ requesters
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_read,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      err,
  output logic                      m_transfer,
  output logic                      m_read_write,
  output logic [ADDR_W-1:0]         m_w_paddr,
  output logic [ADDR_W-1:0]         m_r_paddr,
  output logic [DATA_W-1:0]         m_w_data,
  input  logic                      m_ready,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic                      m_slverr
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int TMR_W = idx_width(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  arb_state_t         state;
  arb_state_t         state_next;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [NUM_REQ-1:0] gnt_q;
  logic               pick_any;
  logic               load_cmd;
  logic               time_up;
  logic               cmd_read;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [DATA_W-1:0]  cmd_wdata;
  logic [DATA_W-1:0]  rdata_q;
  logic               err_q;
  logic [TMR_W-1:0]   timer;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (req),
    .ptr        (ptr),
    .gnt_onehot (pick_onehot),
    .gnt_idx    (pick_idx),
    .any_req    (pick_any)
  );

  assign time_up = (timer == TMR_LAST);
  assign gnt     = gnt_q;
  assign rdata   = rdata_q;
  assign err     = err_q;

  // State register; reset abandons any in-flight transfer without a done pulse
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the master-side and done outputs of each state
  always_comb begin
    state_next   = state;
    load_cmd     = 1'b0;
    done         = '0;
    m_transfer   = 1'b0;
    m_read_write = 1'b0;
    m_w_paddr    = '0;
    m_r_paddr    = '0;
    m_w_data     = '0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          load_cmd   = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        m_transfer   = 1'b1;
        m_read_write = cmd_read;
        if (cmd_read) begin
          m_r_paddr = cmd_addr;
        end else begin
          m_w_paddr = cmd_addr;
          m_w_data  = cmd_wdata;
        end
        if (m_ready || time_up) begin
          state_next = RESP;
        end
      end
      RESP: begin
        done[win_idx] = 1'b1;
        state_next    = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture the winner's command and pulse its grant for one cycle
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      gnt_q     <= '0;
      win_idx   <= '0;
      cmd_read  <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else begin
      gnt_q <= load_cmd ? pick_onehot : '0;
      if (load_cmd) begin
        win_idx   <= pick_idx;
        cmd_read  <= req_read[pick_idx];
        cmd_addr  <= ADDR_W'(req_addr >> (int'(pick_idx) * ADDR_W));
        cmd_wdata <= DATA_W'(req_wdata >> (int'(pick_idx) * DATA_W));
      end
    end
  end

  // Count BUSY cycles from zero so a silent slave cannot stall the bus
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      timer <= '0;
    end else if (state == BUSY && state_next == BUSY) begin
      timer <= timer + 1'b1;
    end else begin
      timer <= '0;
    end
  end

  // Record the response; a completion in the timeout cycle still wins
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state == BUSY) begin
      if (m_ready) begin
        rdata_q <= cmd_read ? m_rdata : '0;
        err_q   <= m_slverr;
      end else if (time_up) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  // Rotate priority to just past the requester that was served
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ptr <= '0;
    end else if (state == RESP) begin
      ptr <= (win_idx == IDX_LAST) ? '0 : win_idx + 1'b1;
    end
  end

endmodule
